// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state encoding and fetch constants for the PC/fetch sequencer
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          WORD_BYTES       = 4;

endpackage

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter plus req/ack instruction fetch sequencer
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              misaligned
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              mis_q, mis_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    mis_d   = mis_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH, ST_WAIT: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_EXEC: begin
        // A misaligned target never reaches pc; the unit parks in ERROR until reset.
        if (!stall) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end else begin
            mis_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_WAIT);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + ADDR_W'(WORD_BYTES);
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed boundary cases then random scoreboard run for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .next_pc(next_pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } fetch_t;

  fetch_t exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     n_presented = 0;
  logic   mon_en = 1'b0;
  logic   resp_on = 1'b0;
  logic [31:0] model_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Memory: answers with the word belonging to the requested address; ack also toggles with no request.
  always @(negedge clk) begin
    if (resp_on) begin
      imem_ack   = ($urandom_range(0, 2) == 0);
      imem_rdata = imem_req ? mem_word(imem_addr) : $urandom;
    end
  end

  logic        prev_req, prev_valid;
  logic [31:0] prev_addr, prev_instr, prev_pc;
  fetch_t      cur;

  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      chk("pc_plus4", pc_plus4, pc + 32'd4);
      chk("no_misaligned", 32'(misaligned), 32'd0);
      if (prev_req && imem_ack) begin
        n_presented++;
        chk("present_valid", 32'(instr_valid), 32'd1);
        chk("present_instr", instr, cur.word);
        chk("present_pc", pc, cur.addr);
      end else if (prev_req) begin
        chk("wait_req", 32'(imem_req), 32'd1);
        chk("wait_addr", imem_addr, prev_addr);
      end
      if (prev_valid && stall) begin
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_instr", instr, prev_instr);
        chk("stall_pc", pc, prev_pc);
      end
      if (prev_valid && !stall) chk("commit_req", 32'(imem_req), 32'd1);
      if (imem_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_fetch got=%h exp=none", imem_addr);
        end else begin
          cur = exp_q.pop_front();
          chk("fetch_addr", imem_addr, cur.addr);
        end
      end
      prev_req   = imem_req;
      prev_valid = instr_valid;
      prev_addr  = imem_addr;
      prev_instr = instr;
      prev_pc    = pc;
    end else begin
      prev_req   = 1'b0;
      prev_valid = 1'b0;
    end
  end

  task automatic drive_random();
    stall = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 7))
      5:       next_pc = model_pc;
      6:       next_pc = $urandom & 32'hFFFF_FFFC;
      7:       next_pc = 32'hFFFF_FFFC;
      default: next_pc = model_pc + 32'd4;
    endcase
    if (instr_valid && !stall) begin
      exp_q.push_back('{addr: next_pc, word: mem_word(next_pc)});
      model_pc = next_pc;
    end
  endtask

  logic [31:0] p;

  initial begin
    reset = 1'b1; stall = 1'b1; next_pc = 32'h0;
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);

    // Reset values, then first request one cycle after release and valid one later.
    repeat (2) tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_instr", instr, 32'h0);
    at_neg(); reset = 1'b0;
    tick();
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_valid0", 32'(instr_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr, mem_word(32'h0));
    chk("t1_req0", 32'(imem_req), 32'd0);

    // Stalled EXEC holds everything while next_pc and an ack wander.
    for (int i = 0; i < 5; i++) begin
      at_neg();
      next_pc = i[0] ? 32'h0000_0013 : 32'h0000_0080;
      imem_rdata = $urandom;
      tick();
      chk("stall_pc_hold", pc, 32'h0);
      chk("stall_instr_hold", instr, mem_word(32'h0));
      chk("stall_valid_hold", 32'(instr_valid), 32'd1);
      chk("stall_no_req", 32'(imem_req), 32'd0);
    end
    at_neg(); stall = 1'b0; next_pc = 32'h40; imem_ack = 1'b0;
    tick();
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h40);
    chk("t4_valid0", 32'(instr_valid), 32'd0);

    // Slow memory: request held stable through the wait cycles.
    for (int i = 0; i < 3; i++) begin
      at_neg(); imem_rdata = $urandom;
      tick();
      chk("t3_req", 32'(imem_req), 32'd1);
      chk("t3_addr", imem_addr, 32'h40);
      chk("t3_valid0", 32'(instr_valid), 32'd0);
    end
    at_neg(); imem_ack = 1'b1; imem_rdata = 32'hCAFE_0040; stall = 1'b1;
    tick();
    chk("t3_valid", 32'(instr_valid), 32'd1);
    chk("t3_instr", instr, 32'hCAFE_0040);
    chk("t3_pc", pc, 32'h40);

    // Sequential stream with single-cycle ack: one instruction every two cycles.
    p = 32'h40;
    for (int k = 0; k < 4; k++) begin
      at_neg(); stall = 1'b0; p = p + 32'd4; next_pc = p; imem_rdata = mem_word(p);
      tick();
      chk("t2_req", 32'(imem_req), 32'd1);
      chk("t2_addr", imem_addr, p);
      tick();
      chk("t2_valid", 32'(instr_valid), 32'd1);
      chk("t2_instr", instr, mem_word(p));
    end

    // Top of the address space wraps to zero.
    at_neg(); next_pc = 32'hFFFF_FFFC; imem_rdata = mem_word(32'hFFFF_FFFC);
    tick();
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_plus4", pc_plus4, 32'h0);
    p = 32'hFFFF_FFFC; p = p + 32'd4;
    at_neg(); next_pc = p; imem_rdata = mem_word(p);
    tick();
    chk("t5_wrap_req", 32'(imem_req), 32'd1);
    chk("t5_wrap_addr", imem_addr, 32'h0);
    tick();

    // Misaligned target is sticky and stops fetching until reset.
    at_neg(); next_pc = 32'h102;
    tick();
    chk("t6_mis", 32'(misaligned), 32'd1);
    chk("t6_pc", pc, 32'h0);
    chk("t6_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      at_neg(); imem_ack = $urandom_range(0, 1) == 1; next_pc = 32'h200;
      tick();
      chk("t6_no_req", 32'(imem_req), 32'd0);
      chk("t6_mis_sticky", 32'(misaligned), 32'd1);
    end
    at_neg(); reset = 1'b1;
    tick();
    chk("t6_mis_clr", 32'(misaligned), 32'd0);
    at_neg(); reset = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(32'h0); stall = 1'b1;
    tick(); tick();
    at_neg(); stall = 1'b0; next_pc = 32'h80; imem_ack = 1'b0;
    tick(); tick();
    chk("t6_wait_addr", imem_addr, 32'h80);
    at_neg(); reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    chk("t6_rst_pc", pc, 32'h0);
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_instr", instr, 32'h0);

    // Random traffic against the scoreboard.
    stall = 1'b1;
    tick();
    at_neg(); reset = 1'b0;
    model_pc = 32'h0;
    exp_q.push_back('{addr: 32'h0, word: mem_word(32'h0)});
    resp_on = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      at_neg();
    end
    mon_en = 1'b0; resp_on = 1'b0;
    chk("rand_progress", 32'(n_presented > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
